// File: rtl/reg_write_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_sched_pkg
// Description : Shared definitions for the register write scheduler: the
//               controller state encoding and the helper used to derive
//               address and pointer widths from the requester and register
//               counts.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package reg_write_sched_pkg;

  // Controller states. IDLE and GRANT arbitrate identically; GRANT only
  // records that a grant was issued on the previous edge.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_SWEEP = 2'd2
  } state_e;

  // ceil(log2(n)), never below 1, so that a count of one still gets a
  // legal one-bit index.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Default bank size and the register address width derived from it.
  localparam int RWS_NREG_DEFAULT = 8;
  localparam int RWS_AW_DEFAULT   = clog2_min1(RWS_NREG_DEFAULT);

endpackage : reg_write_sched_pkg
`default_nettype wire

// File: rtl/reg_write_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. The requester at index
//               ptr_i has the highest priority, then ptr_i+1, wrapping
//               around. Output is one-hot, or all zero when nothing requests.
// Ports       : req_i  [N-1:0]  request vector
//               ptr_i  [PW-1:0] index of the highest-priority requester
//               gnt_o  [N-1:0]  one-hot grant
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  localparam logic [N-1:0] c_one = N'(1);

  logic [N-1:0]   w_req_rot;
  logic [N-1:0]   w_first;
  logic [2*N-1:0] w_gnt_dbl;

  always_comb begin
    // Rotate so the priority requester lands on bit 0.
    w_req_rot = N'({req_i, req_i} >> ptr_i);
    // Isolate the lowest set bit: first requester at or after the pointer.
    w_first   = w_req_rot & (~w_req_rot + c_one);
    // Rotate the winner back into requester numbering.
    w_gnt_dbl = {{N{1'b0}}, w_first} << ptr_i;
    gnt_o     = w_gnt_dbl[N-1:0] | w_gnt_dbl[2*N-1:N];
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/reg_write_sched.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_sched
// Description : Write scheduler for an external dff register bank. Grants one
//               requester per cycle in round-robin order and forwards its
//               address/data as a one-hot write enable plus broadcast data.
//               A sweep request zeroes the whole bank, one register per
//               cycle in ascending order, before arbitration resumes.
// Ports       : clk        clock, rising edge
//               clr        synchronous active-high reset
//               req        [NREQ]       per-requester level request
//               req_addr   [NREQ*AW]    per-requester register address
//               req_data   [NREQ*DW]    per-requester write data
//               sweep_req  single-cycle zero-all request
//               gnt        [NREQ]       one-hot grant pulse (registered)
//               wr_e       [NREG]       one-hot bank write enable (registered)
//               wr_data    [DW]         bank write data (registered)
//               busy       high while sweeping
//               sweep_done one-cycle pulse after the last sweep write
// Revision    : 1.0 - initial release
// ============================================================================
module reg_write_sched
  import reg_write_sched_pkg::*;
#(
  parameter int  NREQ = 4,
  parameter int  NREG = RWS_NREG_DEFAULT,
  parameter int  DW   = 8,
  localparam int AW   = clog2_min1(NREG),
  localparam int PW   = clog2_min1(NREQ)
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic                 sweep_req,
  output logic [NREQ-1:0]      gnt,
  output logic [NREG-1:0]      wr_e,
  output logic [DW-1:0]        wr_data,
  output logic                 busy,
  output logic                 sweep_done
);

  localparam logic [NREG-1:0] c_we_one   = NREG'(1);
  localparam logic [AW-1:0]   c_idx_one  = AW'(1);
  localparam logic [AW-1:0]   c_idx_last = AW'(NREG - 1);
  localparam logic [PW-1:0]   c_ptr_one  = PW'(1);
  localparam logic [PW-1:0]   c_ptr_last = PW'(NREQ - 1);

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREG-1:0]   wr_e_q, wr_e_d;
  logic [DW-1:0]     wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [NREQ-1:0]   w_arb_gnt;
  logic [PW-1:0]     w_win_idx;
  logic [PW-1:0]     w_ptr_nxt;
  logic [AW-1:0]     w_sel_addr;
  logic [DW-1:0]     w_sel_data;
  logic [AW-1:0]     w_idx_inc;

  rr_arbiter #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr_arbiter (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (w_arb_gnt)
  );

  // Winner index and its address/data slices, selected by the one-hot grant.
  always_comb begin
    w_win_idx  = '0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_arb_gnt[i]) begin
        w_win_idx  = PW'(i);
        w_sel_addr = req_addr[i*AW +: AW];
        w_sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Priority restarts just after the requester that was granted.
  assign w_ptr_nxt = (w_win_idx == c_ptr_last) ? '0 : (w_win_idx + c_ptr_one);
  // Sweep index wraps naturally since NREG is a power of two.
  assign w_idx_inc = idx_q + c_idx_one;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    gnt_d     = '0;
    wr_e_d    = '0;
    wr_data_d = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_GRANT: begin
        if (sweep_req) begin
          // Sweep beats any pending request; register 0 is zeroed first.
          state_d = ST_SWEEP;
          idx_d   = '0;
          wr_e_d  = c_we_one;
          busy_d  = 1'b1;
        end else if (|req) begin
          state_d   = ST_GRANT;
          gnt_d     = w_arb_gnt;
          wr_e_d    = c_we_one << w_sel_addr;
          wr_data_d = w_sel_data;
          ptr_d     = w_ptr_nxt;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SWEEP: begin
        // idx_q is the register whose write enable is currently driven.
        if (idx_q == c_idx_last) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d  = w_idx_inc;
          wr_e_d = c_we_one << w_idx_inc;
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      gnt_q     <= '0;
      wr_e_q    <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      gnt_q     <= gnt_d;
      wr_e_q    <= wr_e_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign gnt        = gnt_q;
  assign wr_e       = wr_e_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign sweep_done = done_q;

endmodule : reg_write_sched
`default_nettype wire

// File: tb/tb_reg_write_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_write_sched
// Description : Self-checking bench for reg_write_sched. A cycle-level
//               behavioural model predicts every output; directed sequences
//               pin the model with literal values, then random traffic runs.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_reg_write_sched;

  localparam int NREQ = 4;
  localparam int NREG = 8;
  localparam int DW   = 8;
  localparam int AW   = 3;

  logic                 clk = 1'b0;
  logic                 clr;
  logic [NREQ-1:0]      req;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic                 sweep_req;
  logic [NREQ-1:0]      gnt;
  logic [NREG-1:0]      wr_e;
  logic [DW-1:0]        wr_data;
  logic                 busy;
  logic                 sweep_done;

  always #5 clk = ~clk;

  reg_write_sched #(
    .NREQ (NREQ),
    .NREG (NREG),
    .DW   (DW)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .req        (req),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .sweep_req  (sweep_req),
    .gnt        (gnt),
    .wr_e       (wr_e),
    .wr_data    (wr_data),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  // External register bank driven by the scheduler.
  logic [DW-1:0] bank [NREG];
  always @(posedge clk) begin
    for (int k = 0; k < NREG; k++)
      if (wr_e[k]) bank[k] <= wr_data;
  end

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_sweep = -1 when not sweeping, otherwise the register being zeroed.
  int              m_ptr   = 0;
  int              m_sweep = -1;
  int              m_cand;
  int              m_nxt;
  bit              m_found;
  logic [NREQ-1:0] exp_gnt     = '0;
  logic [NREG-1:0] exp_wr_e    = '0;
  logic [DW-1:0]   exp_wr_data = '0;
  logic            exp_busy    = 1'b0;
  logic            exp_done    = 1'b0;

  always @(posedge clk) begin
    exp_gnt     = '0;
    exp_wr_e    = '0;
    exp_wr_data = '0;
    exp_busy    = 1'b0;
    exp_done    = 1'b0;
    if (clr) begin
      m_ptr   = 0;
      m_sweep = -1;
    end else if (m_sweep >= 0) begin
      if (m_sweep == NREG - 1) begin
        m_sweep  = -1;
        exp_done = 1'b1;
      end else begin
        m_sweep = m_sweep + 1;
        exp_wr_e[m_sweep] = 1'b1;
        exp_busy = 1'b1;
      end
    end else if (sweep_req) begin
      m_sweep     = 0;
      exp_wr_e[0] = 1'b1;
      exp_busy    = 1'b1;
    end else begin
      m_found = 1'b0;
      m_nxt   = m_ptr;
      for (int j = 0; j < NREQ; j++) begin
        m_cand = (m_ptr + j) % NREQ;
        if (!m_found && req[m_cand]) begin
          m_found = 1'b1;
          exp_gnt[m_cand] = 1'b1;
          exp_wr_e[req_addr[m_cand*AW +: AW]] = 1'b1;
          exp_wr_data = req_data[m_cand*DW +: DW];
          m_nxt = (m_cand + 1) % NREQ;
        end
      end
      m_ptr = m_nxt;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_gnt",  32'(gnt),        32'(exp_gnt));
      chk("model_wr_e", 32'(wr_e),       32'(exp_wr_e));
      chk("model_data", 32'(wr_data),    32'(exp_wr_data));
      chk("model_busy", 32'(busy),       32'(exp_busy));
      chk("model_done", 32'(sweep_done), 32'(exp_done));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[r] = 1'b1;
    req_addr[r*AW +: AW] = a;
    req_data[r*DW +: DW] = d;
  endtask

  task automatic pulse_reset();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic write_one(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit seen;
    seen = 1'b0;
    set_req(r, a, d);
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (gnt[r]) begin
        seen   = 1'b1;
        req[r] = 1'b0;
      end
    end
    chk("write_one_timeout", 32'(seen), 32'(1));
    req[r] = 1'b0;
  endtask

  int pulses;

  initial begin
    clr = 1'b1; sweep_req = 1'b0; req = '0; req_addr = '0; req_data = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_gnt",  32'(gnt), 0);
    chk("rst_wr_e", 32'(wr_e), 0);
    chk("rst_data", 32'(wr_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(sweep_done), 0);
    clr = 1'b0;

    // Single write, latency 1.
    set_req(0, 3'd3, 8'hA5);
    @(negedge clk);
    chk("t1_gnt",  32'(gnt), 32'h1);
    chk("t1_wr_e", 32'(wr_e), 32'h08);
    chk("t1_data", 32'(wr_data), 32'hA5);
    req[0] = 1'b0;
    @(negedge clk);
    chk("t1_idle_gnt",  32'(gnt), 0);
    chk("t1_idle_wr_e", 32'(wr_e), 0);

    // All four requesting: grants 0,1,2,3 back to back.
    pulse_reset();
    for (int r = 0; r < NREQ; r++) set_req(r, AW'(r), DW'(8'h10 + r));
    for (int k = 0; k < NREQ; k++) begin
      @(negedge clk);
      chk("t2_order", 32'(gnt), 32'(1) << k);
      req = req & ~gnt;
    end
    @(negedge clk);
    chk("t2_after", 32'(gnt), 0);

    // Same address from two requesters: later grant wins.
    pulse_reset();
    set_req(1, 3'd5, 8'h11);
    set_req(2, 3'd5, 8'h22);
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (wr_e[5]) pulses++;
      req = req & ~gnt;
    end
    chk("t3_pulses", 32'(pulses), 32'd2);
    chk("t3_bank5",  32'(bank[5]), 32'h22);

    // Sweep with a concurrent request; a mid-sweep sweep_req is ignored.
    set_req(1, 3'd6, 8'h77);
    sweep_req = 1'b1;
    @(negedge clk);
    sweep_req = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      chk("t4_busy", 32'(busy), 32'd1);
      chk("t4_wr_e", 32'(wr_e), 32'(1) << k);
      chk("t4_data", 32'(wr_data), 0);
      chk("t4_gnt",  32'(gnt), 0);
      sweep_req = (k == 3);
      @(negedge clk);
    end
    sweep_req = 1'b0;
    chk("t4_done",      32'(sweep_done), 32'd1);
    chk("t4_busy_fall", 32'(busy), 0);
    for (int k = 0; k < NREG; k++) chk("t4_bank_zero", 32'(bank[k]), 0);
    @(negedge clk);
    chk("t4_gnt_after", 32'(gnt), 32'h2);
    chk("t4_wr_e_after", 32'(wr_e), 32'h40);
    chk("t4_data_after", 32'(wr_data), 32'h77);
    req[1] = 1'b0;
    @(negedge clk);

    // Abort a sweep with clr in its 4th cycle.
    for (int r = 0; r < 3; r++) write_one(2, AW'(r), DW'(8'h5A + r));
    @(negedge clk);
    chk("t5_pre0", 32'(bank[0]), 32'h5A);
    chk("t5_pre2", 32'(bank[2]), 32'h5C);
    sweep_req = 1'b1;
    @(negedge clk);
    sweep_req = 1'b0;
    chk("t5_first", 32'(wr_e), 32'h01);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t5_fourth", 32'(wr_e), 32'h08);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t5_abort_wr_e", 32'(wr_e), 0);
    chk("t5_abort_busy", 32'(busy), 0);
    chk("t5_abort_done", 32'(sweep_done), 0);
    chk("t5_abort_gnt",  32'(gnt), 0);
    for (int k = 0; k < 3; k++) chk("t5_bank_zero", 32'(bank[k]), 0);
    @(negedge clk);
    chk("t5_no_done", 32'(sweep_done), 0);
    chk("t5_idle_busy", 32'(busy), 0);

    // Requesters 0 and 3 held continuously: strict alternation.
    set_req(0, 3'd1, 8'hC0);
    set_req(3, 3'd2, 8'hC3);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("t6_alt", 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h8);
    end
    req = '0;
    @(negedge clk);

    // Random traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      clr       = ($urandom % 400 == 0);
      sweep_req = ($urandom % 50 == 0);
      for (int r = 0; r < NREQ; r++) begin
        if (req[r] && gnt[r]) begin
          if ($urandom % 8 != 0) req[r] = 1'b0;
        end else if (!req[r] && ($urandom % 3 == 0)) begin
          set_req(r, AW'($urandom), DW'($urandom));
        end
      end
    end
    clr = 1'b0; sweep_req = 1'b0; req = '0;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule : tb_reg_write_sched
`default_nettype wire

// File: doc/reg_write_sched.md
REG_WRITE_SCHED -- requirements
Module: reg_write_sched

Interface
REQ-001 Parameter NREQ, default 4: number of write requesters.
REQ-002 Parameter NREG, default 8: number of dff-based registers in the bank; power of two.
REQ-003 Parameter DW, default 8: register data width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 clr  input  1  reset, synchronous, active-high.
REQ-006 req  input  NREQ  per-requester write request, level; held until granted.
REQ-007 req_addr  input  NREQ*log2(NREG)  per-requester target register, slice i for requester i.
REQ-008 req_data  input  NREQ*DW  per-requester write data, slice i for requester i.
REQ-009 sweep_req  input  1  single-cycle pulse requesting zeroing of all registers.
REQ-010 gnt  output  NREQ  one-hot grant pulse, registered.
REQ-011 wr_e  output  NREG  one-hot register write enables to the bank, registered.
REQ-012 wr_data  output  DW  data broadcast to all bank registers, registered.
REQ-013 busy  output  1  high while in SWEEP.
REQ-014 sweep_done  output  1  one-cycle pulse after the last sweep write.

Function
REQ-015 The FSM SHALL have states IDLE, GRANT and SWEEP.
REQ-016 In IDLE or GRANT with sweep_req low: if any req is high, the block SHALL grant exactly one requester per cycle using round-robin priority.
REQ-017 Round-robin priority SHALL start at the requester after the last granted one; after reset it SHALL start at requester 0.
REQ-018 A grant to requester i SHALL produce gnt[i]=1 and wr_e[req_addr_i]=1 with wr_data=req_data_i.
REQ-019 These outputs SHALL appear in the cycle after req[i] is sampled, giving a latency of 1.
REQ-020 gnt and wr_e SHALL each be high for exactly one cycle per grant.
REQ-021 A requester SHALL drop req in the cycle it sees gnt.
REQ-022 A req still high in the gnt cycle SHALL be treated as a new request.
REQ-023 State GRANT SHALL be entered when a grant issues; IDLE SHALL be entered when no req is pending.
REQ-024 If two requesters target the same address, the writes SHALL be serialized in grant order, and the later write SHALL win.
REQ-025 sweep_req SHALL have priority over all reqs when sampled in IDLE or GRANT. On sampling it, the FSM SHALL enter SWEEP.
REQ-026 In SWEEP, the block SHALL assert wr_e[k] with wr_data=0 for k=0..NREG-1, one register per cycle in ascending order, with gnt held at 0 and busy=1.
REQ-027 After k=NREG-1, sweep_done SHALL pulse in the next cycle, busy SHALL fall in that same cycle, and the FSM SHALL return to IDLE.
REQ-028 Pending reqs during SWEEP SHALL wait; arbitration SHALL resume in the cycle after sweep_done.
REQ-029 sweep_req asserted during SWEEP SHALL be ignored.
REQ-030 The round-robin pointer SHALL be unchanged by a sweep.
REQ-031 The sweep index SHALL be log2(NREG) bits wide and SHALL wrap to 0 on leaving SWEEP.
REQ-032 With no request and no sweep, all outputs SHALL be 0.

Reset
REQ-033 When clr is high at a clock edge, the block SHALL set state=IDLE, rr pointer=0, sweep index=0, and gnt, wr_e, wr_data, busy and sweep_done all to 0.
REQ-034 clr asserted mid-SWEEP SHALL abort the sweep with no sweep_done pulse; registers already zeroed stay zeroed.
REQ-035 clr SHALL have priority over sweep_req and req in the same cycle.

Structure
REQ-036 The FSM state encoding and the derived address width localparam SHALL live in the shared processor package.
REQ-037 The round-robin arbiter SHALL be a sub-module rr_arbiter (inputs req, pointer; outputs one-hot grant), instantiated once.
REQ-038 The bank itself SHALL remain outside this block, with one dff per bit driven by wr_e[k] and wr_data.

Verification
REQ-039 After clr, req=4'b0001 with addr0=3 and data0=8'hA5 for one cycle -> next cycle gnt=4'b0001, wr_e=8'b0000_1000, wr_data=8'hA5; then all outputs are 0.
REQ-040 req=4'b1111 held, each requester dropping on its gnt -> grants in order 0,1,2,3, one per cycle, with no gaps.
REQ-041 Requesters 1 and 2 both write addr 5, with data 8'h11 and 8'h22 -> two wr_e[5] pulses; the final bank value is 8'h22.
REQ-042 sweep_req pulse together with req=4'b0010 -> busy for 8 cycles, wr_e walking from 8'h01 to 8'h80 with wr_data=0, then sweep_done; gnt[1] follows in the next cycle.
REQ-043 clr asserted in the 4th sweep cycle -> the next cycle shows all outputs 0, state IDLE and no sweep_done; registers 0..2 read 0.
REQ-044 Continuous requests from 0 and 3 -> grants alternate 0,3,0,3, with no starvation over 16 cycles.
